// File: rtl/serial_a_paralelo_sync_pkg.sv
// Shared PHY symbol table and receive-FSM encodings for the lane deserializer.
// The upstream serializer uses the same symbol values.
package serial_a_paralelo_sync_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam logic [7:0]  COM_SYM  = 8'hBC;
  localparam logic [7:0]  IDLE_SYM = 8'h7C;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SEEK   = 2'b01,
    LOCKED = 2'b10
  } rx_state_t;

  // X on the line makes == evaluate to X, and an X condition takes the else branch,
  // so an unknown bit can never produce a false match.
  function automatic logic sym_match(input logic [7:0] a, input logic [7:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/desplazador_serial.sv
// MSB-first 8-bit shift register with a free-running 3-bit bit counter.
// The counter is held at zero while cnt_clr is high.
module desplazador_serial
  import serial_a_paralelo_sync_pkg::*;
(
  input  logic              clk32f,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] nxt,
  output logic [2:0]        bit_cnt
);

  logic [DATA_W-1:0] shreg;

  assign nxt = {shreg[DATA_W-2:0], serial_in};

  always_ff @(posedge clk32f) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      shreg <= nxt;
      if (cnt_clr) bit_cnt <= '0;
      else         bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/serial_a_paralelo_sync.sv
// Lane deserializer: hunts for COM alignment, locks after COM_LOCK aligned COMs,
// then emits one byte every 8 bit clocks with valid and idle strobes.
module serial_a_paralelo_sync
  import serial_a_paralelo_sync_pkg::*;
#(
  parameter logic [7:0] COM      = COM_SYM,
  parameter logic [7:0] IDLE     = IDLE_SYM,
  parameter int         COM_LOCK = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic       active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       idle_det
);

  localparam logic [3:0] LOCK_N = 4'(COM_LOCK);

  rx_state_t   state_q, state_d;
  logic [3:0]  com_cnt_q, com_cnt_d;
  logic        active_d, valid_d, idle_d;
  logic [7:0]  data_d;
  logic [7:0]  nxt;
  logic [2:0]  bit_cnt;
  logic        boundary;

  desplazador_serial u_shift (
    .clk32f    (clk32f),
    .reset     (reset),
    .serial_in (serial_in),
    .cnt_clr   (state_q == HUNT),
    .nxt       (nxt),
    .bit_cnt   (bit_cnt)
  );

  assign boundary = (bit_cnt == 3'd7);

  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    active_d  = active;
    data_d    = data_out;
    valid_d   = 1'b0;
    idle_d    = 1'b0;
    case (state_q)
      HUNT: begin
        if (sym_match(nxt, COM)) begin
          com_cnt_d = 4'd1;
          if (LOCK_N == 4'd1) begin
            state_d  = LOCKED;
            active_d = 1'b1;
            data_d   = nxt;
            valid_d  = 1'b1;
          end else begin
            state_d = SEEK;
          end
        end
      end
      SEEK: begin
        if (boundary) begin
          if (sym_match(nxt, COM)) begin
            if (com_cnt_q + 4'd1 >= LOCK_N) begin
              com_cnt_d = LOCK_N;
              state_d   = LOCKED;
              active_d  = 1'b1;
              data_d    = nxt;
              valid_d   = 1'b1;
            end else begin
              com_cnt_d = com_cnt_q + 4'd1;
            end
          end else begin
            // Bits already shifted in are kept; hunting continues from them next edge.
            state_d   = HUNT;
            com_cnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          data_d  = nxt;
          valid_d = 1'b1;
          idle_d  = sym_match(nxt, IDLE);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk32f) begin
    if (reset) begin
      state_q   <= HUNT;
      com_cnt_q <= 4'd0;
      active    <= 1'b0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      idle_det  <= 1'b0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
      active    <= active_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      idle_det  <= idle_d;
    end
  end

endmodule

// File: tb/tb_serial_a_paralelo_sync.sv
// Directed, table-driven bench for the lane deserializer: alignment, lock, relock, idle flagging.
module tb_serial_a_paralelo_sync;

  logic       clk32f = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic       idle_det;

  int n_cmp = 0;
  int n_bad = 0;

  logic       exp_active = 1'b0;
  logic [7:0] exp_data = 8'h00;

  serial_a_paralelo_sync dut (
    .clk32f    (clk32f),
    .reset     (reset),
    .serial_in (serial_in),
    .active    (active),
    .data_out  (data_out),
    .valid_out (valid_out),
    .idle_det  (idle_det)
  );

  always #5 clk32f = ~clk32f;

  typedef struct {
    logic       rst;     // one reset edge before this byte
    int         njunk;   // leading junk bits before the byte
    logic [2:0] junk;    // junk bits, MSB first
    logic [7:0] sym;
    logic       v;       // valid strobe on the byte's last bit
    logic       a;       // active after the byte's last bit
    logic       i;       // idle_det on the byte's last bit
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string nm, input int idx, input int bitn,
                     input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s vec=%0d bit=%0d actual=%h required=%h", nm, idx, bitn, act, req);
    end
  endtask

  task automatic check_all(input int idx, input int bitn, input logic v, input logic i);
    chk("valid_out", idx, bitn, {7'b0, valid_out}, {7'b0, v});
    chk("idle_det",  idx, bitn, {7'b0, idle_det},  {7'b0, i});
    chk("active",    idx, bitn, {7'b0, active},    {7'b0, exp_active});
    chk("data_out",  idx, bitn, data_out,          exp_data);
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk32f);
    #1;
  endtask

  task automatic do_reset(input int edges, input int idx);
    reset = 1'b1;
    for (int k = 0; k < edges; k++) begin
      serial_in = 1'($urandom);
      @(posedge clk32f);
      #1;
      exp_active = 1'b0;
      exp_data   = 8'h00;
      check_all(idx, -1 - k, 1'b0, 1'b0);
    end
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic rst, input int nj, input logic [2:0] j,
                              input logic [7:0] s, input logic v, input logic a, input logic i);
    vec_t r;
    r.rst = rst; r.njunk = nj; r.junk = j; r.sym = s; r.v = v; r.a = a; r.i = i;
    return r;
  endfunction

  initial begin
    // Lock on 4 COMs, then idle stream
    tbl[0]  = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 0, 3'b000, 8'hBC, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 0, 3'b000, 8'h7C, 1'b1, 1'b1, 1'b1);
    tbl[5]  = mk(1'b0, 0, 3'b000, 8'h7C, 1'b1, 1'b1, 1'b1);
    // Three junk bits shift every strobe by 3 cycles
    tbl[6]  = mk(1'b1, 3, 3'b101, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 0, 3'b000, 8'hBC, 1'b1, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 0, 3'b000, 8'h7C, 1'b1, 1'b1, 1'b1);
    // Broken COM run restarts the count
    tbl[11] = mk(1'b1, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 0, 3'b000, 8'h55, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[18] = mk(1'b0, 0, 3'b000, 8'hBC, 1'b1, 1'b1, 1'b0);
    tbl[19] = mk(1'b0, 0, 3'b000, 8'h7C, 1'b1, 1'b1, 1'b1);
    tbl[20] = mk(1'b0, 0, 3'b000, 8'h7C, 1'b1, 1'b1, 1'b1);
    // Reset while locked, relock on fresh COMs, then mixed payload
    tbl[21] = mk(1'b1, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[22] = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[23] = mk(1'b0, 0, 3'b000, 8'hBC, 1'b0, 1'b0, 1'b0);
    tbl[24] = mk(1'b0, 0, 3'b000, 8'hBC, 1'b1, 1'b1, 1'b0);
    tbl[25] = mk(1'b0, 0, 3'b000, 8'hA5, 1'b1, 1'b1, 1'b0);
    tbl[26] = mk(1'b0, 0, 3'b000, 8'h7C, 1'b1, 1'b1, 1'b1);
    tbl[27] = mk(1'b0, 0, 3'b000, 8'h3C, 1'b1, 1'b1, 1'b0);

    // Reset held for 3 edges with random line data
    do_reset(3, -1);

    for (int n = 0; n < 28; n++) begin
      if (tbl[n].rst) do_reset(1, n);
      for (int j = 0; j < tbl[n].njunk; j++) begin
        logic [2:0] jb;
        jb = tbl[n].junk;
        send_bit(jb[2 - j]);
        check_all(n, 100 + j, 1'b0, 1'b0);
      end
      for (int b = 7; b >= 0; b--) begin
        send_bit(tbl[n].sym[b]);
        if (b == 0) begin
          exp_active = tbl[n].a;
          if (tbl[n].v) exp_data = tbl[n].sym;
          check_all(n, b, tbl[n].v, tbl[n].i);
        end else begin
          check_all(n, b, 1'b0, 1'b0);
        end
      end
    end

    // Mid-byte reset while locked: outputs clear on that edge, COMs after it are not enough until 4 arrive
    for (int b = 7; b >= 4; b--) begin
      send_bit(tbl[4].sym[b]);
      check_all(99, b, 1'b0, 1'b0);
    end
    do_reset(1, 99);
    for (int r = 0; r < 3; r++) begin
      for (int b = 7; b >= 0; b--) begin
        send_bit(tbl[0].sym[b]);
        check_all(200 + r, b, 1'b0, 1'b0);
      end
    end
    for (int b = 7; b >= 0; b--) begin
      send_bit(tbl[0].sym[b]);
      if (b == 0) begin
        exp_active = 1'b1;
        exp_data   = 8'hBC;
        check_all(203, b, 1'b1, 1'b0);
      end else begin
        check_all(203, b, 1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
